// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the data memory bank.
package dmem_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    // Number of byte-lane address bits inside one DATA_W word.
    function automatic int unsigned lane_bits(input int unsigned data_w);
        return (data_w == 64) ? 3 : 2;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store byte enables/shifted data, load extraction/extension.
module dmem_lane_align
    import dmem_pkg::*;
#(
    parameter  int unsigned DATA_W = 32,
    localparam int unsigned LANE_W = lane_bits(DATA_W),
    localparam int unsigned NB     = DATA_W / 8
) (
    input  logic [1:0]        size,
    input  logic [LANE_W-1:0] lane,
    input  logic              is_unsigned,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rword,
    output logic [NB-1:0]     be_c,
    output logic [DATA_W-1:0] wdata_c,
    output logic [DATA_W-1:0] rdata_c,
    output logic              misalign_c
);

    logic [LANE_W-1:0] align_mask;
    logic [NB-1:0]     field_be;
    logic [DATA_W-1:0] keep;
    logic [DATA_W-1:0] shifted;
    logic [LANE_W+2:0] bit_off;
    logic              sign;

    always_comb begin
        align_mask = '0;
        field_be   = '0;
        keep       = '0;
        sign       = 1'b0;
        bit_off    = {lane, 3'b000};
        shifted    = rword >> bit_off;
        case (size)
            SZ_B: begin
                field_be = NB'(1);
                keep     = DATA_W'(8'hFF);
                sign     = shifted[7];
            end
            SZ_H: begin
                align_mask = LANE_W'(1);
                field_be   = NB'(3);
                keep       = DATA_W'(16'hFFFF);
                sign       = shifted[15];
            end
            SZ_W: begin
                align_mask = LANE_W'(3);
                field_be   = NB'(15);
                keep       = DATA_W'(32'hFFFF_FFFF);
                sign       = shifted[31];
            end
            default: begin
                align_mask = LANE_W'(7);
                field_be   = '1;
                keep       = '1;
                sign       = shifted[DATA_W-1];
            end
        endcase
        misalign_c = |(lane & align_mask);
        be_c       = field_be << lane;
        wdata_c    = wdata << bit_off;
        // Bits above the selected field come from its MSB or are zero.
        rdata_c    = (shifted & keep) | ((!is_unsigned && sign) ? ~keep : '0);
    end

endmodule

// File: rtl/dmem_bank.sv
// Single-port data memory with sub-word access, error flagging and post-reset clear sweep.
module dmem_bank
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned DEPTH      = 128,
    parameter int unsigned ADDR_W     = 32,
    parameter bit          INIT_CLEAR = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    localparam int unsigned LANE_W = lane_bits(DATA_W);
    localparam int unsigned NB     = DATA_W / 8;
    localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned WIDX_W = ADDR_W - LANE_W;
    localparam state_t      RST_ST = INIT_CLEAR ? CLEAR : READY;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state;
    logic [IDX_W-1:0]  clr_cnt;
    logic [LANE_W-1:0] lane;
    logic [WIDX_W-1:0] widx;
    logic [IDX_W-1:0]  idx;
    logic              range_err;
    logic              size_err;
    logic              misalign;
    logic              err;
    logic              accept;
    logic [NB-1:0]     be;
    logic [DATA_W-1:0] wdata_sh;
    logic [DATA_W-1:0] rdata_ext;

    assign lane      = req_addr[LANE_W-1:0];
    assign widx      = req_addr[ADDR_W-1:LANE_W];
    assign idx       = widx[IDX_W-1:0];
    assign range_err = (widx >= WIDX_W'(DEPTH));
    assign size_err  = (req_size == SZ_D) && (DATA_W != 64);
    assign err       = misalign || range_err || size_err;
    assign accept    = req_valid && req_ready;

    dmem_lane_align #(
        .DATA_W (DATA_W)
    ) u_align (
        .size        (req_size),
        .lane        (lane),
        .is_unsigned (req_unsigned),
        .wdata       (req_wdata),
        .rword       (mem[idx]),
        .be_c        (be),
        .wdata_c     (wdata_sh),
        .rdata_c     (rdata_ext),
        .misalign_c  (misalign)
    );

    // FSM, sweep counter and registered response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RST_ST;
            clr_cnt   <= '0;
            busy      <= INIT_CLEAR;
            req_ready <= !INIT_CLEAR;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= accept;
            rsp_err   <= accept && err;
            rsp_rdata <= (accept && !req_write && !err) ? rdata_ext : '0;
            case (state)
                CLEAR: begin
                    if (clr_cnt == IDX_W'(DEPTH - 1)) begin
                        state     <= READY;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                        clr_cnt   <= '0;
                    end else begin
                        clr_cnt <= clr_cnt + IDX_W'(1);
                    end
                end
                default: begin
                    state <= READY;
                end
            endcase
        end
    end

    // Array: sweep writes zero; stores merge only the enabled bytes.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[clr_cnt] <= '0;
        end else if (accept && req_write && !err) begin
            for (int b = 0; b < int'(NB); b++) begin
                if (be[b]) mem[idx][b*8 +: 8] <= wdata_sh[b*8 +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_bank.sv
// Bench for dmem_bank: vector table, randomized ops against a byte model, reset/sweep sequences.
module tb_dmem_bank;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 128;
    localparam int unsigned ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_write = 1'b0;
    logic [1:0]        req_size = 2'd0;
    logic              req_unsigned = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              busy;

    dmem_bank #(
        .DATA_W     (DATA_W),
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W),
        .INIT_CLEAR (1'b1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
        int          tag;
    } exp_t;

    exp_t       exp_q[$];
    vec_t       vecs[$];
    logic [7:0] mdl [512];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         tag_n = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic mdl_err(input logic [1:0] sz, input logic [31:0] a);
        logic [31:0] amask;
        amask = (32'd1 << sz) - 32'd1;
        return (sz == 2'd3) || ((a & amask) != 32'd0) || (a >= 32'd512);
    endfunction

    function automatic logic [31:0] mdl_load(input logic [1:0] sz, input logic uns, input logic [31:0] a);
        int          nb;
        logic [63:0] v;
        logic [63:0] m;
        nb = 1 << sz;
        v  = '0;
        for (int i = 0; i < nb; i++) v[8*i +: 8] = mdl[a + 32'(i)];
        m = (64'd1 << (8 * nb)) - 64'd1;
        if (!uns && v[8*nb-1]) v = v | ~m;
        return v[31:0];
    endfunction

    task automatic mdl_clear();
        for (int i = 0; i < 512; i++) mdl[i] = 8'h00;
    endtask

    // Drive one request for one cycle and queue its expected response.
    task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] er, input logic ee);
        req_valid    = 1'b1;
        req_write    = wr;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = a;
        req_wdata    = wd;
        exp_q.push_back('{rdata: er, err: ee, due: cyc + 1, tag: tag_n});
        tag_n++;
        if (wr && !ee) begin
            for (int i = 0; i < (1 << sz); i++) mdl[a + 32'(i)] = wd[8*i +: 8];
        end
        @(negedge clk);
    endtask

    task automatic issue_mdl(input logic wr, input logic [1:0] sz, input logic uns,
                             input logic [31:0] a, input logic [31:0] wd);
        logic        e;
        logic [31:0] r;
        e = mdl_err(sz, a);
        r = (wr || e) ? 32'd0 : mdl_load(sz, uns, a);
        issue(wr, sz, uns, a, wd, r, e);
    endtask

    task automatic drain();
        req_valid = 1'b0;
        req_write = 1'b0;
        repeat (3) @(negedge clk);
        chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_sweep(input string name);
        int n;
        n = 0;
        while (n < 300) begin
            @(negedge clk);
            n++;
            if (req_ready) break;
        end
        chk({name, "_len"}, 32'(n), 32'd128);
        chk({name, "_busy_done"}, 32'(busy), 32'd0);
    endtask

    // Response scoreboard: pop and compare on every response strobe.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got rdata 0x%08h err %0b with nothing pending", rsp_rdata, rsp_err);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk($sformatf("rsp%0d_rdata", e.tag), rsp_rdata, e.rdata);
                    chk($sformatf("rsp%0d_err", e.tag), 32'(rsp_err), 32'(e.err));
                    chk($sformatf("rsp%0d_latency", e.tag), 32'(cyc), 32'(e.due));
                end
            end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
                exp_t e;
                e = exp_q.pop_front();
                checks++;
                errors++;
                $display("FAIL rsp%0d_missing: got no rsp_valid at cycle %0d required at %0d", e.tag, cyc, e.due);
            end
        end
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b1;
        wait_sweep("sweep1");
        mdl_clear();

        vecs = '{
            '{1'b0, 2'd2, 1'b0, 32'h1FC, 32'h0,        32'h0000_0000, 1'b0},
            '{1'b1, 2'd2, 1'b0, 32'h010, 32'hDEADBEEF, 32'h0000_0000, 1'b0},
            '{1'b1, 2'd0, 1'b0, 32'h011, 32'h0000005A, 32'h0000_0000, 1'b0},
            '{1'b0, 2'd2, 1'b0, 32'h010, 32'h0,        32'hDEAD_5AEF, 1'b0},
            '{1'b0, 2'd0, 1'b0, 32'h013, 32'h0,        32'hFFFF_FFDE, 1'b0},
            '{1'b0, 2'd0, 1'b1, 32'h013, 32'h0,        32'h0000_00DE, 1'b0},
            '{1'b0, 2'd1, 1'b0, 32'h012, 32'h0,        32'hFFFF_DEAD, 1'b0},
            '{1'b0, 2'd1, 1'b1, 32'h012, 32'h0,        32'h0000_DEAD, 1'b0},
            '{1'b0, 2'd1, 1'b0, 32'h011, 32'h0,        32'h0000_0000, 1'b1},
            '{1'b1, 2'd2, 1'b0, 32'h202, 32'hFFFFFFFF, 32'h0000_0000, 1'b1},
            '{1'b1, 2'd2, 1'b0, 32'h200, 32'h11111111, 32'h0000_0000, 1'b1},
            '{1'b1, 2'd0, 1'b0, 32'h012, 32'hAB,       32'h0000_0000, 1'b0},
            '{1'b1, 2'd2, 1'b0, 32'h013, 32'h77777777, 32'h0000_0000, 1'b1},
            '{1'b0, 2'd3, 1'b0, 32'h010, 32'h0,        32'h0000_0000, 1'b1},
            '{1'b0, 2'd2, 1'b0, 32'h010, 32'h0,        32'hDEAB_5AEF, 1'b0},
            '{1'b1, 2'd2, 1'b0, 32'h1FC, 32'h12345678, 32'h0000_0000, 1'b0},
            '{1'b0, 2'd2, 1'b0, 32'h1FC, 32'h0,        32'h1234_5678, 1'b0},
            '{1'b1, 2'd1, 1'b0, 32'h1FE, 32'h00008001, 32'h0000_0000, 1'b0},
            '{1'b0, 2'd1, 1'b0, 32'h1FE, 32'h0,        32'hFFFF_8001, 1'b0},
            '{1'b0, 2'd2, 1'b1, 32'h1FC, 32'h0,        32'h8001_5678, 1'b0},
            '{1'b0, 2'd0, 1'b0, 32'h1FD, 32'h0,        32'h0000_0056, 1'b0}
        };
        foreach (vecs[i])
            issue(vecs[i].wr, vecs[i].size, vecs[i].uns, vecs[i].addr,
                  vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_err);
        drain();

        // Randomized traffic against the byte model, with occasional idle gaps
        for (int i = 0; i < 80; i++) begin
            logic [1:0]  sz;
            logic [31:0] a;
            sz = 2'($urandom_range(0, 3));
            a  = 32'($urandom_range(0, 32'h23F));
            if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
            issue_mdl(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
            if ($urandom_range(0, 7) == 0) begin
                req_valid = 1'b0;
                @(negedge clk);
            end
        end
        drain();

        // Reset mid-sweep: abort and restart with the full count
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        chk("mid_sweep_busy", 32'(busy), 32'd1);
        chk("mid_sweep_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd1);
        chk("abort_ready", 32'(req_ready), 32'd0);
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_sweep("sweep2");
        mdl_clear();
        issue(1'b0, 2'd2, 1'b0, 32'h1FC, 32'h0, 32'h0, 1'b0);
        issue(1'b0, 2'd2, 1'b0, 32'h010, 32'h0, 32'h0, 1'b0);
        issue(1'b1, 2'd2, 1'b0, 32'h020, 32'hCAFEF00D, 32'h0, 1'b0);
        issue(1'b0, 2'd1, 1'b0, 32'h022, 32'h0, 32'hFFFF_CAFE, 1'b0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout at cycle %0d required completion", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/dmem_bank.md
# dmem_bank

Parametrised synchronous data memory for the MIPS/uPower datapaths, and the successor to the fixed 128-word, word-only data memory. It adds byte/halfword/word (and, at 64-bit width, doubleword) loads and stores with sign or zero extension. Accesses use a valid/ready request with a one-cycle registered response. Misaligned and out-of-range accesses raise an error flag, and a post-reset clear sweep zeroes the array. It sits between the EX/MEM pipeline register and the MEM/WB register.

## Interface
- DATA_W, 32: word width; 32 or 64 only.
- DEPTH, 128: number of DATA_W words.
- ADDR_W, 32: byte-address width.
- INIT_CLEAR, 1: 1 = zero every word after reset; 0 = skip the sweep (contents undefined).
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  access request present.
- req_ready  out  1  bank can accept a request this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = dword (legal only when DATA_W = 64).
- req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, right-justified.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_rdata  out  DATA_W  load result, extended; 0 for stores and errors.
- rsp_err  out  1  access was misaligned, out of range, or an illegal size.
- busy  out  1  clear sweep in progress.

## Operation
- FSM states: CLEAR and READY.
  - Reset enters CLEAR if INIT_CLEAR = 1, else READY.
  - CLEAR writes 0 to word index clr_cnt, one word per cycle. clr_cnt runs 0..DEPTH-1.
  - The cycle that writes DEPTH-1 moves the FSM to READY.
- busy = (state == CLEAR). req_ready = (state == READY).
- A request is accepted on a clock edge with req_valid && req_ready. There is no backpressure in READY.
- Word index = req_addr >> log2(DATA_W/8). Byte lane = the low log2(DATA_W/8) address bits. Little-endian.
- Error conditions (any one sets the error):
  - lane not a multiple of 2^req_size;
  - word index >= DEPTH;
  - req_size = 3 with DATA_W = 32.
- An errored access writes nothing, returns rsp_rdata = 0 and rsp_err = 1.
- Stores:
  - Only the bytes selected by size and lane are written, taken from the low bytes of req_wdata.
  - Other bytes of the word are preserved.
  - The write commits on the accepting edge.
- Loads:
  - Selected bytes are shifted down to bit 0.
  - Extended to DATA_W by the MSB of the selected field (signed) or by zeros (unsigned).
  - A word load with DATA_W = 32 is passed through unchanged.
- Stores also produce a response: rsp_valid = 1, rsp_rdata = 0, rsp_err as computed.
- No simulation-only display or time-dependent write gating.

## Timing
- Reset values: rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, clr_cnt = 0.
  - busy = INIT_CLEAR, req_ready = !INIT_CLEAR.
- Asserting rst_n low mid-sweep or mid-access aborts immediately.
  - After reset the sweep restarts from index 0.
  - No response is issued for a request accepted on the edge coinciding with reset.
- Sweep duration: exactly DEPTH cycles from the first rising edge after reset release. req_ready rises on the following cycle.
- Latency: the response is registered. rsp_valid is high in the cycle after acceptance, for exactly one cycle per request.
- Back-to-back requests give a response every cycle.
- Read-after-write: a load accepted the cycle after a store to the same word sees the new data.
- Write-then-read on the same word in the same cycle cannot occur (one port).

## Structure
- Package dmem_pkg holds:
  - size encodings SZ_B/SZ_H/SZ_W/SZ_D;
  - state enum {CLEAR, READY};
  - a helper function returning lane bits for a given DATA_W.
- Sub-module dmem_lane_align (combinational) takes size, lane, unsigned flag and DATA_W.
  - It produces the store byte-enable mask and the shifted write data.
  - It produces the extracted, extended load data and the misalignment flag.
- The top level holds the array, the FSM/sweep counter and the response registers.

## Test plan
- Reset with INIT_CLEAR = 1, DEPTH = 128 → busy high for 128 cycles, req_ready rises on cycle 129, a word load of addr 0x1FC returns 0.
- Word store 0xDEADBEEF at 0x10, then byte store 0x5A at 0x11 → word load at 0x10 returns 0xDEAD5AEF.
- Signed byte load at 0x13 → 0xFFFFFFDE. Unsigned byte load at 0x13 → 0x000000DE. Signed half load at 0x12 → 0xFFFFDEAD.
- Half load at 0x11 and word store at 0x202 (index 128) → rsp_err = 1, rsp_rdata = 0, memory unchanged.
- Store then load to the same address on consecutive cycles → responses on consecutive cycles, the load returns the new data.
- Assert rst_n low at sweep cycle 60 → busy stays high, and the sweep restarts with the full 128-cycle count.
